// File: rtl/z80fi_collector.sv
// Z80FI retirement-packet producer: accumulates per-cycle datapath events
// for one instruction and emits a registered single-cycle packet at retire.
`ifndef REG_SELECT
`define REG_SELECT [3:0]
`endif

module z80fi_collector (
    input  logic              clk,
    input  logic              reset,
    input  logic              ev_start,
    input  logic [15:0]       ev_pc,
    input  logic              ev_fetch,
    input  logic [7:0]        ev_fetch_data,
    input  logic              ev_rrd,
    input  logic `REG_SELECT  ev_rrd_num,
    input  logic [15:0]       ev_rrd_data,
    input  logic              ev_rwr,
    input  logic `REG_SELECT  ev_rwr_num,
    input  logic [15:0]       ev_rwr_data,
    input  logic              ev_mrd,
    input  logic [15:0]       ev_mrd_addr,
    input  logic [7:0]        ev_mrd_data,
    input  logic              ev_mwr,
    input  logic [15:0]       ev_mwr_addr,
    input  logic [7:0]        ev_mwr_data,
    input  logic              ev_done,
    input  logic [15:0]       ev_next_pc,
    output logic              z80fi_valid,
    output logic [31:0]       z80fi_insn,
    output logic [2:0]        z80fi_insn_len,
    output logic [15:0]       z80fi_pc_rdata,
    output logic [15:0]       z80fi_pc_wdata,
    output logic              z80fi_reg1_rd,
    output logic `REG_SELECT  z80fi_reg1_rnum,
    output logic [15:0]       z80fi_reg1_rdata,
    output logic              z80fi_reg2_rd,
    output logic `REG_SELECT  z80fi_reg2_rnum,
    output logic [15:0]       z80fi_reg2_rdata,
    output logic              z80fi_reg_wr,
    output logic `REG_SELECT  z80fi_reg_wnum,
    output logic [15:0]       z80fi_reg_wdata,
    output logic              z80fi_mem_rd,
    output logic [15:0]       z80fi_mem_raddr,
    output logic [7:0]        z80fi_mem_rdata,
    output logic              z80fi_mem_rd2,
    output logic [15:0]       z80fi_mem_raddr2,
    output logic [7:0]        z80fi_mem_rdata2,
    output logic              z80fi_mem_wr,
    output logic [15:0]       z80fi_mem_waddr,
    output logic [7:0]        z80fi_mem_wdata,
    output logic              z80fi_mem_wr2,
    output logic [15:0]       z80fi_mem_waddr2,
    output logic [7:0]        z80fi_mem_wdata2,
    output logic              z80fi_err
);

    typedef enum logic {IDLE, COLLECT} state_t;

    typedef struct packed {
        logic [31:0]      insn;
        logic [2:0]       len;
        logic [15:0]      pc_rdata;
        logic             reg1_rd;
        logic `REG_SELECT reg1_rnum;
        logic [15:0]      reg1_rdata;
        logic             reg2_rd;
        logic `REG_SELECT reg2_rnum;
        logic [15:0]      reg2_rdata;
        logic             reg_wr;
        logic `REG_SELECT reg_wnum;
        logic [15:0]      reg_wdata;
        logic             mem_rd;
        logic [15:0]      mem_raddr;
        logic [7:0]       mem_rdata;
        logic             mem_rd2;
        logic [15:0]      mem_raddr2;
        logic [7:0]       mem_rdata2;
        logic             mem_wr;
        logic [15:0]      mem_waddr;
        logic [7:0]       mem_wdata;
        logic             mem_wr2;
        logic [15:0]      mem_waddr2;
        logic [7:0]       mem_wdata2;
    } acc_t;

    state_t      state_reg, state_next;
    acc_t        acc_reg, acc_next;
    logic        ovf_reg, ovf_next;
    acc_t        out_reg;
    logic [15:0] pc_wdata_reg;
    logic        valid_reg, err_reg;

    acc_t        emit_src;
    logic        emit_ovf;
    logic        retire;
    logic        abandon;

    always_comb begin
        state_next = state_reg;
        acc_next   = acc_reg;
        ovf_next   = ovf_reg;

        if (ev_start) begin
            acc_next          = '0;
            acc_next.pc_rdata = ev_pc;
            ovf_next          = 1'b0;
            state_next        = COLLECT;
        end else if (state_reg == COLLECT && ev_done) begin
            state_next = IDLE;
        end

        if (ev_start || state_reg == COLLECT) begin
            if (ev_fetch) begin
                if (!acc_next.len[2]) begin
                    acc_next.insn[{acc_next.len[1:0], 3'b000} +: 8] = ev_fetch_data;
                    acc_next.len = acc_next.len + 3'd1;
                end else begin
                    ovf_next = 1'b1;
                end
            end
            if (ev_rrd) begin
                if (!acc_next.reg1_rd) begin
                    acc_next.reg1_rd    = 1'b1;
                    acc_next.reg1_rnum  = ev_rrd_num;
                    acc_next.reg1_rdata = ev_rrd_data;
                end else if (!acc_next.reg2_rd) begin
                    acc_next.reg2_rd    = 1'b1;
                    acc_next.reg2_rnum  = ev_rrd_num;
                    acc_next.reg2_rdata = ev_rrd_data;
                end else begin
                    ovf_next = 1'b1;
                end
            end
            if (ev_rwr) begin
                if (!acc_next.reg_wr) begin
                    acc_next.reg_wr    = 1'b1;
                    acc_next.reg_wnum  = ev_rwr_num;
                    acc_next.reg_wdata = ev_rwr_data;
                end else begin
                    ovf_next = 1'b1;
                end
            end
            if (ev_mrd) begin
                if (!acc_next.mem_rd) begin
                    acc_next.mem_rd    = 1'b1;
                    acc_next.mem_raddr = ev_mrd_addr;
                    acc_next.mem_rdata = ev_mrd_data;
                end else if (!acc_next.mem_rd2) begin
                    acc_next.mem_rd2    = 1'b1;
                    acc_next.mem_raddr2 = ev_mrd_addr;
                    acc_next.mem_rdata2 = ev_mrd_data;
                end else begin
                    ovf_next = 1'b1;
                end
            end
            if (ev_mwr) begin
                if (!acc_next.mem_wr) begin
                    acc_next.mem_wr    = 1'b1;
                    acc_next.mem_waddr = ev_mwr_addr;
                    acc_next.mem_wdata = ev_mwr_data;
                end else if (!acc_next.mem_wr2) begin
                    acc_next.mem_wr2    = 1'b1;
                    acc_next.mem_waddr2 = ev_mwr_addr;
                    acc_next.mem_wdata2 = ev_mwr_data;
                end else begin
                    ovf_next = 1'b1;
                end
            end
        end

        // With a same-cycle start, this cycle's events belong to the new
        // instruction, so the retiring packet comes from the held state.
        emit_src = ev_start ? acc_reg : acc_next;
        emit_ovf = ev_start ? ovf_reg : ovf_next;
        retire   = (state_reg == COLLECT) && ev_done;
        abandon  = (state_reg == COLLECT) && ev_start && !ev_done;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            acc_reg      <= '0;
            ovf_reg      <= 1'b0;
            out_reg      <= '0;
            pc_wdata_reg <= 16'h0000;
            valid_reg    <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            state_reg <= state_next;
            acc_reg   <= acc_next;
            ovf_reg   <= ovf_next;
            valid_reg <= retire && !emit_ovf;
            err_reg   <= abandon || (retire && emit_ovf);
            if (retire && !emit_ovf) begin
                out_reg      <= emit_src;
                pc_wdata_reg <= ev_next_pc;
            end
        end
    end

    assign z80fi_valid      = valid_reg;
    assign z80fi_err        = err_reg;
    assign z80fi_insn       = out_reg.insn;
    assign z80fi_insn_len   = out_reg.len;
    assign z80fi_pc_rdata   = out_reg.pc_rdata;
    assign z80fi_pc_wdata   = pc_wdata_reg;
    assign z80fi_reg1_rd    = out_reg.reg1_rd;
    assign z80fi_reg1_rnum  = out_reg.reg1_rnum;
    assign z80fi_reg1_rdata = out_reg.reg1_rdata;
    assign z80fi_reg2_rd    = out_reg.reg2_rd;
    assign z80fi_reg2_rnum  = out_reg.reg2_rnum;
    assign z80fi_reg2_rdata = out_reg.reg2_rdata;
    assign z80fi_reg_wr     = out_reg.reg_wr;
    assign z80fi_reg_wnum   = out_reg.reg_wnum;
    assign z80fi_reg_wdata  = out_reg.reg_wdata;
    assign z80fi_mem_rd     = out_reg.mem_rd;
    assign z80fi_mem_raddr  = out_reg.mem_raddr;
    assign z80fi_mem_rdata  = out_reg.mem_rdata;
    assign z80fi_mem_rd2    = out_reg.mem_rd2;
    assign z80fi_mem_raddr2 = out_reg.mem_raddr2;
    assign z80fi_mem_rdata2 = out_reg.mem_rdata2;
    assign z80fi_mem_wr     = out_reg.mem_wr;
    assign z80fi_mem_waddr  = out_reg.mem_waddr;
    assign z80fi_mem_wdata  = out_reg.mem_wdata;
    assign z80fi_mem_wr2    = out_reg.mem_wr2;
    assign z80fi_mem_waddr2 = out_reg.mem_waddr2;
    assign z80fi_mem_wdata2 = out_reg.mem_wdata2;

endmodule

// File: tb/tb_z80fi_collector.sv
// Scoreboard bench for z80fi_collector: expected packets are queued when
// ev_done/ev_start is driven and compared when valid/err appears.
`ifndef REG_SELECT
`define REG_SELECT [3:0]
`endif

module tb_z80fi_collector;

    logic clk = 1'b0;
    logic reset;
    logic ev_start, ev_fetch, ev_rrd, ev_rwr, ev_mrd, ev_mwr, ev_done;
    logic [15:0] ev_pc, ev_rrd_data, ev_rwr_data, ev_mrd_addr, ev_mwr_addr, ev_next_pc;
    logic [7:0]  ev_fetch_data, ev_mrd_data, ev_mwr_data;
    logic `REG_SELECT ev_rrd_num, ev_rwr_num;

    logic        z80fi_valid, z80fi_err;
    logic [31:0] z80fi_insn;
    logic [2:0]  z80fi_insn_len;
    logic [15:0] z80fi_pc_rdata, z80fi_pc_wdata;
    logic        z80fi_reg1_rd, z80fi_reg2_rd, z80fi_reg_wr;
    logic `REG_SELECT z80fi_reg1_rnum, z80fi_reg2_rnum, z80fi_reg_wnum;
    logic [15:0] z80fi_reg1_rdata, z80fi_reg2_rdata, z80fi_reg_wdata;
    logic        z80fi_mem_rd, z80fi_mem_rd2, z80fi_mem_wr, z80fi_mem_wr2;
    logic [15:0] z80fi_mem_raddr, z80fi_mem_raddr2, z80fi_mem_waddr, z80fi_mem_waddr2;
    logic [7:0]  z80fi_mem_rdata, z80fi_mem_rdata2, z80fi_mem_wdata, z80fi_mem_wdata2;

    z80fi_collector dut (
        .clk(clk), .reset(reset),
        .ev_start(ev_start), .ev_pc(ev_pc),
        .ev_fetch(ev_fetch), .ev_fetch_data(ev_fetch_data),
        .ev_rrd(ev_rrd), .ev_rrd_num(ev_rrd_num), .ev_rrd_data(ev_rrd_data),
        .ev_rwr(ev_rwr), .ev_rwr_num(ev_rwr_num), .ev_rwr_data(ev_rwr_data),
        .ev_mrd(ev_mrd), .ev_mrd_addr(ev_mrd_addr), .ev_mrd_data(ev_mrd_data),
        .ev_mwr(ev_mwr), .ev_mwr_addr(ev_mwr_addr), .ev_mwr_data(ev_mwr_data),
        .ev_done(ev_done), .ev_next_pc(ev_next_pc),
        .z80fi_valid(z80fi_valid), .z80fi_insn(z80fi_insn), .z80fi_insn_len(z80fi_insn_len),
        .z80fi_pc_rdata(z80fi_pc_rdata), .z80fi_pc_wdata(z80fi_pc_wdata),
        .z80fi_reg1_rd(z80fi_reg1_rd), .z80fi_reg1_rnum(z80fi_reg1_rnum), .z80fi_reg1_rdata(z80fi_reg1_rdata),
        .z80fi_reg2_rd(z80fi_reg2_rd), .z80fi_reg2_rnum(z80fi_reg2_rnum), .z80fi_reg2_rdata(z80fi_reg2_rdata),
        .z80fi_reg_wr(z80fi_reg_wr), .z80fi_reg_wnum(z80fi_reg_wnum), .z80fi_reg_wdata(z80fi_reg_wdata),
        .z80fi_mem_rd(z80fi_mem_rd), .z80fi_mem_raddr(z80fi_mem_raddr), .z80fi_mem_rdata(z80fi_mem_rdata),
        .z80fi_mem_rd2(z80fi_mem_rd2), .z80fi_mem_raddr2(z80fi_mem_raddr2), .z80fi_mem_rdata2(z80fi_mem_rdata2),
        .z80fi_mem_wr(z80fi_mem_wr), .z80fi_mem_waddr(z80fi_mem_waddr), .z80fi_mem_wdata(z80fi_mem_wdata),
        .z80fi_mem_wr2(z80fi_mem_wr2), .z80fi_mem_waddr2(z80fi_mem_waddr2), .z80fi_mem_wdata2(z80fi_mem_wdata2),
        .z80fi_err(z80fi_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        is_err;
        logic [31:0] cyc;
        logic [31:0] insn;
        logic [2:0]  len;
        logic [15:0] pc_r, pc_w;
        logic        r1;  logic [3:0] r1n; logic [15:0] r1d;
        logic        r2;  logic [3:0] r2n; logic [15:0] r2d;
        logic        w;   logic [3:0] wn;  logic [15:0] wd;
        logic        m1;  logic [15:0] m1a; logic [7:0] m1d;
        logic        m2;  logic [15:0] m2a; logic [7:0] m2d;
        logic        w1;  logic [15:0] w1a; logic [7:0] w1d;
        logic        w2;  logic [15:0] w2a; logic [7:0] w2d;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic clr_ev();
        ev_start = 0; ev_pc = 0; ev_fetch = 0; ev_fetch_data = 0;
        ev_rrd = 0; ev_rrd_num = 0; ev_rrd_data = 0;
        ev_rwr = 0; ev_rwr_num = 0; ev_rwr_data = 0;
        ev_mrd = 0; ev_mrd_addr = 0; ev_mrd_data = 0;
        ev_mwr = 0; ev_mwr_addr = 0; ev_mwr_data = 0;
        ev_done = 0; ev_next_pc = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        clr_ev();
    endtask

    // The driven event is sampled at the next edge; the response is visible the cycle after it.
    task automatic push_pkt(input exp_t e);
        e.is_err = 1'b0;
        e.cyc = cyc + 1;
        q.push_back(e);
    endtask

    task automatic push_err();
        exp_t e;
        e = '0;
        e.is_err = 1'b1;
        e.cyc = cyc + 1;
        q.push_back(e);
    endtask

    task automatic start(input logic [15:0] pc);
        ev_start = 1; ev_pc = pc;
    endtask
    task automatic fetch(input logic [7:0] b);
        ev_fetch = 1; ev_fetch_data = b;
    endtask
    task automatic done(input logic [15:0] npc);
        ev_done = 1; ev_next_pc = npc;
    endtask

    always @(negedge clk) begin
        if (z80fi_valid || z80fi_err) begin
            if (q.size() == 0) begin
                check_eq("unexpected_pkt", {62'd0, z80fi_valid, z80fi_err}, 64'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check_eq("pkt_cycle", cyc, e.cyc);
                check_eq("valid", z80fi_valid, !e.is_err);
                check_eq("err", z80fi_err, e.is_err);
                if (!e.is_err) begin
                    check_eq("insn", z80fi_insn, e.insn);
                    check_eq("insn_len", z80fi_insn_len, e.len);
                    check_eq("pc_rdata", z80fi_pc_rdata, e.pc_r);
                    check_eq("pc_wdata", z80fi_pc_wdata, e.pc_w);
                    check_eq("reg1", {z80fi_reg1_rd, z80fi_reg1_rnum, z80fi_reg1_rdata}, {e.r1, e.r1n, e.r1d});
                    check_eq("reg2", {z80fi_reg2_rd, z80fi_reg2_rnum, z80fi_reg2_rdata}, {e.r2, e.r2n, e.r2d});
                    check_eq("regw", {z80fi_reg_wr, z80fi_reg_wnum, z80fi_reg_wdata}, {e.w, e.wn, e.wd});
                    check_eq("mem_rd", {z80fi_mem_rd, z80fi_mem_raddr, z80fi_mem_rdata}, {e.m1, e.m1a, e.m1d});
                    check_eq("mem_rd2", {z80fi_mem_rd2, z80fi_mem_raddr2, z80fi_mem_rdata2}, {e.m2, e.m2a, e.m2d});
                    check_eq("mem_wr", {z80fi_mem_wr, z80fi_mem_waddr, z80fi_mem_wdata}, {e.w1, e.w1a, e.w1d});
                    check_eq("mem_wr2", {z80fi_mem_wr2, z80fi_mem_waddr2, z80fi_mem_wdata2}, {e.w2, e.w2a, e.w2d});
                    $display("packet pc=%04h insn=%08h len=%0d next=%04h", z80fi_pc_rdata, z80fi_insn, z80fi_insn_len, z80fi_pc_wdata);
                end else begin
                    $display("error pulse at cycle %0d", cyc);
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_flags"}, {z80fi_valid, z80fi_err, z80fi_reg1_rd, z80fi_reg2_rd, z80fi_reg_wr,
                                  z80fi_mem_rd, z80fi_mem_rd2, z80fi_mem_wr, z80fi_mem_wr2}, 64'd0);
        check_eq({tag, "_insn"}, {z80fi_insn, z80fi_insn_len}, 64'd0);
        check_eq({tag, "_pc"}, {z80fi_pc_rdata, z80fi_pc_wdata}, 64'd0);
        check_eq({tag, "_rdata"}, {z80fi_reg1_rdata, z80fi_reg2_rdata, z80fi_reg_wdata}, 64'd0);
        check_eq({tag, "_mem"}, {z80fi_mem_raddr, z80fi_mem_rdata, z80fi_mem_waddr2, z80fi_mem_wdata2}, 64'd0);
    endtask

    initial begin
        exp_t e;
        clr_ev();
        reset = 1;
        repeat (3) step();
        check_all_zero("reset");
        reset = 0;
        step();

        // LD A,(HL)
        start(16'h0100); fetch(8'h7E); step();
        ev_rrd = 1; ev_rrd_num = 4'd4; ev_rrd_data = 16'h8000; step();
        ev_mrd = 1; ev_mrd_addr = 16'h8000; ev_mrd_data = 8'h5A; step();
        ev_rwr = 1; ev_rwr_num = 4'd7; ev_rwr_data = 16'h005A; done(16'h0101);
        e = '0; e.insn = 32'h0000007E; e.len = 1; e.pc_r = 16'h0100; e.pc_w = 16'h0101;
        e.r1 = 1; e.r1n = 4'd4; e.r1d = 16'h8000; e.m1 = 1; e.m1a = 16'h8000; e.m1d = 8'h5A;
        e.w = 1; e.wn = 4'd7; e.wd = 16'h005A;
        push_pkt(e); step();
        step();

        // 4-byte instruction, fetch in done cycle
        start(16'h0200); fetch(8'hDD); step();
        fetch(8'h36); step();
        fetch(8'h05); step();
        fetch(8'h77); done(16'h0204);
        e = '0; e.insn = 32'h770536DD; e.len = 4; e.pc_r = 16'h0200; e.pc_w = 16'h0204;
        push_pkt(e); step();

        // 5-byte overflow
        start(16'h0210); fetch(8'hDD); step();
        fetch(8'h36); step();
        fetch(8'h05); step();
        fetch(8'h77); step();
        fetch(8'h00); done(16'h0215); push_err(); step();
        step();

        // Back-to-back with a gap before the second done
        start(16'h0300); fetch(8'h00); step();
        done(16'h0301); start(16'h0301); fetch(8'h3C);
        e = '0; e.insn = 32'h00000000; e.len = 1; e.pc_r = 16'h0300; e.pc_w = 16'h0301;
        push_pkt(e); step();
        step(); step();
        done(16'h0302);
        e = '0; e.insn = 32'h0000003C; e.len = 1; e.pc_r = 16'h0301; e.pc_w = 16'h0302;
        push_pkt(e); step();

        // Done on consecutive cycles
        start(16'h0400); fetch(8'h00); step();
        done(16'h0401); start(16'h0401); fetch(8'h04);
        e = '0; e.len = 1; e.pc_r = 16'h0400; e.pc_w = 16'h0401;
        push_pkt(e); step();
        done(16'h0402);
        e = '0; e.insn = 32'h00000004; e.len = 1; e.pc_r = 16'h0401; e.pc_w = 16'h0402;
        push_pkt(e); step();
        step();

        // PUSH BC
        start(16'h0500); fetch(8'hC5); step();
        ev_rrd = 1; ev_rrd_num = 4'd1; ev_rrd_data = 16'h1234; step();
        ev_mwr = 1; ev_mwr_addr = 16'hFFFD; ev_mwr_data = 8'h12; step();
        ev_mwr = 1; ev_mwr_addr = 16'hFFFC; ev_mwr_data = 8'h34; done(16'h0501);
        e = '0; e.insn = 32'h000000C5; e.len = 1; e.pc_r = 16'h0500; e.pc_w = 16'h0501;
        e.r1 = 1; e.r1n = 4'd1; e.r1d = 16'h1234;
        e.w1 = 1; e.w1a = 16'hFFFD; e.w1d = 8'h12; e.w2 = 1; e.w2a = 16'hFFFC; e.w2d = 8'h34;
        push_pkt(e); step();

        // Third memory write overflows
        start(16'h0510); fetch(8'hC5); step();
        ev_mwr = 1; ev_mwr_addr = 16'hFFFD; ev_mwr_data = 8'h12; step();
        ev_mwr = 1; ev_mwr_addr = 16'hFFFC; ev_mwr_data = 8'h34; step();
        ev_mwr = 1; ev_mwr_addr = 16'hFFFB; ev_mwr_data = 8'h56; done(16'h0511);
        push_err(); step();

        // EX (SP),HL: both read slots of each kind
        start(16'h0520); fetch(8'hE3); step();
        ev_rrd = 1; ev_rrd_num = 4'd8; ev_rrd_data = 16'hFFF0; step();
        ev_rrd = 1; ev_rrd_num = 4'd4; ev_rrd_data = 16'hABCD;
        ev_mrd = 1; ev_mrd_addr = 16'hFFF0; ev_mrd_data = 8'h11; step();
        ev_mrd = 1; ev_mrd_addr = 16'hFFF1; ev_mrd_data = 8'h22;
        ev_mwr = 1; ev_mwr_addr = 16'hFFF0; ev_mwr_data = 8'hCD; step();
        ev_mwr = 1; ev_mwr_addr = 16'hFFF1; ev_mwr_data = 8'hAB;
        ev_rwr = 1; ev_rwr_num = 4'd4; ev_rwr_data = 16'h2211; done(16'h0521);
        e = '0; e.insn = 32'h000000E3; e.len = 1; e.pc_r = 16'h0520; e.pc_w = 16'h0521;
        e.r1 = 1; e.r1n = 4'd8; e.r1d = 16'hFFF0; e.r2 = 1; e.r2n = 4'd4; e.r2d = 16'hABCD;
        e.w = 1; e.wn = 4'd4; e.wd = 16'h2211;
        e.m1 = 1; e.m1a = 16'hFFF0; e.m1d = 8'h11; e.m2 = 1; e.m2a = 16'hFFF1; e.m2d = 8'h22;
        e.w1 = 1; e.w1a = 16'hFFF0; e.w1d = 8'hCD; e.w2 = 1; e.w2a = 16'hFFF1; e.w2d = 8'hAB;
        push_pkt(e); step();

        // Third register read overflows
        start(16'h0530); fetch(8'hED); step();
        ev_rrd = 1; ev_rrd_num = 4'd1; ev_rrd_data = 16'h0001; step();
        ev_rrd = 1; ev_rrd_num = 4'd2; ev_rrd_data = 16'h0002; step();
        ev_rrd = 1; ev_rrd_num = 4'd3; ev_rrd_data = 16'h0003; done(16'h0532);
        push_err(); step();

        // Abandon: start while collecting
        start(16'h0600); fetch(8'h01); ev_rrd = 1; ev_rrd_num = 4'd2; ev_rrd_data = 16'h7777; step();
        start(16'h0700); fetch(8'h3E); push_err(); step();
        fetch(8'h09); step();
        done(16'h0702);
        e = '0; e.insn = 32'h0000093E; e.len = 2; e.pc_r = 16'h0700; e.pc_w = 16'h0702;
        push_pkt(e); step();

        // Idle noise: ignored, outputs hold the last packet
        for (int i = 0; i < 3; i++) begin
            fetch(8'hAA); ev_rrd = 1; ev_rrd_num = 4'd5; ev_rrd_data = 16'h5555;
            done(16'hBEEF); step();
        end
        step();
        check_eq("idle_hold_insn", {z80fi_insn, z80fi_insn_len}, {32'h0000093E, 3'd2});
        check_eq("idle_hold_pc", {z80fi_pc_rdata, z80fi_pc_wdata}, {16'h0700, 16'h0702});
        check_eq("idle_hold_reg1", z80fi_reg1_rd, 1'b0);

        // Reset mid-instruction
        start(16'h0800); fetch(8'h7E); step();
        fetch(8'h23); step();
        reset = 1; step();
        check_all_zero("midreset");
        reset = 0;
        done(16'h0801); step();
        step(); step();
        check_all_zero("post_reset_done");

        repeat (4) step();
        check_eq("scoreboard_empty", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
